packet_cutter_ctrl: RTL and testbench

- Configuration sequencer for the packet cutter datapath.
- Takes a single byte-length cut setting from the register block and clamps it.
- Derives the cutter's cut_en, cut_words, cut_offset and cut_bytes inputs.
- Commits new settings only at a packet boundary on the cutter's output stream, so no packet is ever cut with mixed configuration. Also keeps packet and cut-packet statistics.

---
 rtl/pkt_cutter_pkg.sv | 42 ++++
 rtl/cut_param_calc.sv | 55 +++++
 rtl/packet_cutter_ctrl.sv | 149 ++++++++++++++
 tb/tb_packet_cutter_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_cutter_pkg.sv
// Shared constants, FSM encodings and shadow-config type for the packet cutter controller.
package pkt_cutter_pkg;

    localparam int unsigned CfgW          = 32;
    localparam int unsigned BPW           = 32;
    localparam int unsigned BpwLog2       = 5;
    localparam int unsigned MIN_CUT_BYTES = 64;
    localparam int unsigned MAX_CUT_BYTES = 16384;

    localparam logic [CfgW-1:0] ALL_ONES = '1;

    // One-hot encodings, matching the cutter datapath style.
    typedef enum logic [2:0] {
        StCfgIdle    = 3'b001,
        StCfgCalc    = 3'b010,
        StCfgPending = 3'b100
    } cfg_state_e;

    typedef enum logic [1:0] {
        StMonOutPkt = 2'b01,
        StMonInPkt  = 2'b10
    } mon_state_e;

    typedef struct packed {
        logic            en;
        logic [CfgW-1:0] words;
        logic [CfgW-1:0] mask;
        logic [CfgW-1:0] bytes;
    } shadow_cfg_t;

    function automatic logic [CfgW-1:0] clamp_len(input logic [CfgW-1:0] len,
                                                  input logic [CfgW-1:0] lo,
                                                  input logic [CfgW-1:0] hi);
        if (len < lo) begin
            return lo;
        end else if (len > hi) begin
            return hi;
        end
        return len;
    endfunction

endpackage

// File: rtl/cut_param_calc.sv
// Latches a clamped cut request, then derives words/mask/bytes into a shadow register.
module cut_param_calc
    import pkt_cutter_pkg::*;
#(
    parameter int unsigned MinCutBytes = MIN_CUT_BYTES,
    parameter int unsigned MaxCutBytes = MAX_CUT_BYTES
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            latch_i,
    input  logic            en_i,
    input  logic [CfgW-1:0] len_i,
    input  logic            calc_i,
    output shadow_cfg_t     shadow_o
);

    logic            req_en_q;
    logic [CfgW-1:0] req_len_q;
    shadow_cfg_t     shadow_d, shadow_q;
    logic [CfgW-1:0] blocks;
    logic [CfgW-1:0] last_bytes;

    // Capture the request with the length already clamped to the legal range.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_en_q  <= 1'b0;
            req_len_q <= CfgW'(MinCutBytes);
        end else if (latch_i) begin
            req_en_q  <= en_i;
            req_len_q <= clamp_len(len_i, CfgW'(MinCutBytes), CfgW'(MaxCutBytes));
        end
    end

    // Word count excludes the final (partial or full) word; mask keeps its valid MSB bytes.
    always_comb begin
        blocks         = (req_len_q - 1) >> BpwLog2;
        last_bytes     = req_len_q - (blocks << BpwLog2);
        shadow_d.en    = req_en_q;
        shadow_d.words = blocks - 1;
        shadow_d.mask  = ALL_ONES << (CfgW'(BPW) - last_bytes);
        shadow_d.bytes = req_len_q;
    end

    // Shadow values are held until the controller commits them.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadow_q <= '{en: 1'b0, words: '0, mask: ALL_ONES, bytes: '0};
        end else if (calc_i) begin
            shadow_q <= shadow_d;
        end
    end

    assign shadow_o = shadow_q;

endmodule

// File: rtl/packet_cutter_ctrl.sv
// Config sequencer for the packet cutter: commits cut settings only on packet boundaries
// of the monitored output stream and keeps packet statistics.
module packet_cutter_ctrl
    import pkt_cutter_pkg::*;
#(
    parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned C_S_AXI_DATA_WIDTH   = 32,
    parameter int unsigned MIN_CUT_BYTES        = pkt_cutter_pkg::MIN_CUT_BYTES,
    parameter int unsigned MAX_CUT_BYTES        = pkt_cutter_pkg::MAX_CUT_BYTES
) (
    input  logic                          axi_aclk,
    input  logic                          axi_resetn,
    input  logic                          cfg_cut_en,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] cfg_cut_len,
    input  logic                          cfg_update,
    input  logic                          cfg_stats_clear,
    input  logic                          mon_tvalid,
    input  logic                          mon_tready,
    input  logic                          mon_tlast,
    input  logic [15:0]                   mon_tuser_len,
    output logic                          cut_en,
    output logic [C_S_AXI_DATA_WIDTH-1:0] cut_words,
    output logic [C_S_AXI_DATA_WIDTH-1:0] cut_offset,
    output logic [C_S_AXI_DATA_WIDTH-1:0] cut_bytes,
    output logic                          update_pending,
    output logic                          update_done,
    output logic [C_S_AXI_DATA_WIDTH-1:0] pkt_count,
    output logic [C_S_AXI_DATA_WIDTH-1:0] cut_pkt_count
);

    // The arithmetic is fixed to the package geometry; reject mismatched builds.
    if (C_M_AXIS_DATA_WIDTH != BPW * 8 || C_S_AXI_DATA_WIDTH != CfgW ||
        C_M_AXIS_TUSER_WIDTH < 16) begin : g_param_check
        $error("packet_cutter_ctrl: unsupported width parameters");
    end

    cfg_state_e      cfg_state_q, cfg_state_d;
    mon_state_e      mon_state_q, mon_state_d;
    shadow_cfg_t     shadow;
    logic            latch, calc, commit, commit_ok, hs, first_beat;
    logic            cut_en_q, update_done_q;
    logic [CfgW-1:0] cut_words_q, cut_offset_q, cut_bytes_q, pkt_count_q, cut_pkt_count_q;

    assign hs         = mon_tvalid & mon_tready;
    assign first_beat = (mon_state_q == StMonOutPkt) & hs;
    // A presented-but-unaccepted first word blocks the commit: the cutter samples config on it.
    assign commit_ok  = ((mon_state_q == StMonOutPkt) & ~mon_tvalid) | (hs & mon_tlast);

    cut_param_calc #(
        .MinCutBytes(MIN_CUT_BYTES),
        .MaxCutBytes(MAX_CUT_BYTES)
    ) u_calc (
        .clk_i   (axi_aclk),
        .rst_ni  (axi_resetn),
        .latch_i (latch),
        .en_i    (cfg_cut_en),
        .len_i   (cfg_cut_len),
        .calc_i  (calc),
        .shadow_o(shadow)
    );

    // Config and monitor state registers.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            cfg_state_q <= StCfgIdle;
            mon_state_q <= StMonOutPkt;
        end else begin
            cfg_state_q <= cfg_state_d;
            mon_state_q <= mon_state_d;
        end
    end

    // Config next state: a new request always restarts CALC (last write wins).
    always_comb begin
        cfg_state_d = cfg_state_q;
        unique case (cfg_state_q)
            StCfgIdle:    if (cfg_update) cfg_state_d = StCfgCalc;
            StCfgCalc:    cfg_state_d = cfg_update ? StCfgCalc : StCfgPending;
            StCfgPending: begin
                if (cfg_update) cfg_state_d = StCfgCalc;
                else if (commit_ok) cfg_state_d = StCfgIdle;
            end
            default:      cfg_state_d = StCfgIdle;
        endcase
    end

    // Config FSM outputs.
    always_comb begin
        latch          = cfg_update;
        calc           = (cfg_state_q == StCfgCalc) & ~cfg_update;
        update_pending = (cfg_state_q == StCfgPending);
        commit         = update_pending & commit_ok;
    end

    // Monitor next state: track whether the output stream is mid-packet.
    always_comb begin
        mon_state_d = mon_state_q;
        unique case (mon_state_q)
            StMonOutPkt: if (hs && !mon_tlast) mon_state_d = StMonInPkt;
            StMonInPkt:  if (hs && mon_tlast) mon_state_d = StMonOutPkt;
            default:     mon_state_d = StMonOutPkt;
        endcase
    end

    // Committed cutter configuration; a commit coincident with a new request uses the old shadow.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            cut_en_q      <= 1'b0;
            cut_words_q   <= '0;
            cut_offset_q  <= ALL_ONES;
            cut_bytes_q   <= '0;
            update_done_q <= 1'b0;
        end else begin
            update_done_q <= commit;
            if (commit) begin
                cut_en_q     <= shadow.en;
                cut_words_q  <= shadow.words;
                cut_offset_q <= shadow.mask;
                cut_bytes_q  <= shadow.bytes;
            end
        end
    end

    // Statistics; clear wins over a same-cycle increment.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            pkt_count_q     <= '0;
            cut_pkt_count_q <= '0;
        end else if (cfg_stats_clear) begin
            pkt_count_q     <= '0;
            cut_pkt_count_q <= '0;
        end else if (first_beat) begin
            pkt_count_q <= pkt_count_q + 1;
            if (cut_en_q && ({16'b0, mon_tuser_len} > cut_bytes_q)) begin
                cut_pkt_count_q <= cut_pkt_count_q + 1;
            end
        end
    end

    assign cut_en        = cut_en_q;
    assign cut_words     = cut_words_q;
    assign cut_offset    = cut_offset_q;
    assign cut_bytes     = cut_bytes_q;
    assign update_done   = update_done_q;
    assign pkt_count     = pkt_count_q;
    assign cut_pkt_count = cut_pkt_count_q;

endmodule

// File: tb/tb_packet_cutter_ctrl.sv
// Directed, table-driven bench for packet_cutter_ctrl.
module tb_packet_cutter_ctrl;

    logic        axi_aclk = 1'b0;
    logic        axi_resetn = 1'b0;
    logic        cfg_cut_en = 1'b0;
    logic [31:0] cfg_cut_len = '0;
    logic        cfg_update = 1'b0;
    logic        cfg_stats_clear = 1'b0;
    logic        mon_tvalid = 1'b0;
    logic        mon_tready = 1'b0;
    logic        mon_tlast = 1'b0;
    logic [15:0] mon_tuser_len = '0;
    logic        cut_en;
    logic [31:0] cut_words, cut_offset, cut_bytes;
    logic        update_pending, update_done;
    logic [31:0] pkt_count, cut_pkt_count;

    int checks = 0;
    int errors = 0;

    packet_cutter_ctrl dut (
        .axi_aclk       (axi_aclk),
        .axi_resetn     (axi_resetn),
        .cfg_cut_en     (cfg_cut_en),
        .cfg_cut_len    (cfg_cut_len),
        .cfg_update     (cfg_update),
        .cfg_stats_clear(cfg_stats_clear),
        .mon_tvalid     (mon_tvalid),
        .mon_tready     (mon_tready),
        .mon_tlast      (mon_tlast),
        .mon_tuser_len  (mon_tuser_len),
        .cut_en         (cut_en),
        .cut_words      (cut_words),
        .cut_offset     (cut_offset),
        .cut_bytes      (cut_bytes),
        .update_pending (update_pending),
        .update_done    (update_done),
        .pkt_count      (pkt_count),
        .cut_pkt_count  (cut_pkt_count)
    );

    always #5 axi_aclk = ~axi_aclk;

    typedef struct {
        logic        en;
        logic [31:0] len;
        logic [31:0] words;
        logic [31:0] offset;
        logic [31:0] bytes;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge axi_aclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " cut_en"}, 32'(cut_en), 32'd0);
        chk({tag, " cut_words"}, cut_words, 32'd0);
        chk({tag, " cut_offset"}, cut_offset, 32'hffff_ffff);
        chk({tag, " cut_bytes"}, cut_bytes, 32'd0);
        chk({tag, " update_pending"}, 32'(update_pending), 32'd0);
        chk({tag, " update_done"}, 32'(update_done), 32'd0);
    endtask

    // One-cycle cfg_update pulse; returns just after the sampling edge.
    task automatic do_update(input logic en, input logic [31:0] len);
        cfg_cut_en  = en;
        cfg_cut_len = len;
        cfg_update  = 1'b1;
        tick();
        cfg_update  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int done_cnt;

        vecs[0] = '{1'b1, 32'd100,    32'd2,   32'hf000_0000, 32'd100};
        vecs[1] = '{1'b1, 32'd64,     32'd0,   32'hffff_ffff, 32'd64};
        vecs[2] = '{1'b1, 32'd10,     32'd0,   32'hffff_ffff, 32'd64};
        vecs[3] = '{1'b1, 32'd65,     32'd1,   32'h8000_0000, 32'd65};
        vecs[4] = '{1'b1, 32'd100000, 32'd510, 32'hffff_ffff, 32'd16384};
        vecs[5] = '{1'b0, 32'd300,    32'd8,   32'hfff0_0000, 32'd300};

        // Reset state
        repeat (2) tick();
        chk_reset_outputs("in_reset");
        axi_resetn = 1'b1;
        tick();
        chk_reset_outputs("after_reset");
        chk("reset pkt_count", pkt_count, 32'd0);
        chk("reset cut_pkt_count", cut_pkt_count, 32'd0);

        // Idle-stream updates: outputs change on the third edge, done pulses once
        for (int i = 0; i < 6; i++) begin
            do_update(vecs[i].en, vecs[i].len);
            chk($sformatf("v%0d pending_e1", i), 32'(update_pending), 32'd0);
            tick();
            chk($sformatf("v%0d pending_e2", i), 32'(update_pending), 32'd1);
            tick();
            chk($sformatf("v%0d cut_en", i), 32'(cut_en), 32'(vecs[i].en));
            chk($sformatf("v%0d cut_words", i), cut_words, vecs[i].words);
            chk($sformatf("v%0d cut_offset", i), cut_offset, vecs[i].offset);
            chk($sformatf("v%0d cut_bytes", i), cut_bytes, vecs[i].bytes);
            chk($sformatf("v%0d done_e3", i), 32'(update_done), 32'd1);
            chk($sformatf("v%0d pending_e3", i), 32'(update_pending), 32'd0);
            tick();
            chk($sformatf("v%0d done_e4", i), 32'(update_done), 32'd0);
        end

        // Update during a 4-beat packet: commit exactly at the tlast handshake
        mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tlast = 1'b0; mon_tuser_len = 16'd500;
        do_update(1'b1, 32'd100);
        tick();
        chk("mid pending_b2", 32'(update_pending), 32'd1);
        chk("mid bytes_b2", cut_bytes, 32'd300);
        tick();
        chk("mid pending_b3", 32'(update_pending), 32'd1);
        chk("mid bytes_b3", cut_bytes, 32'd300);
        mon_tlast = 1'b1;
        tick();
        chk("mid bytes_last", cut_bytes, 32'd100);
        chk("mid words_last", cut_words, 32'd2);
        chk("mid done_last", 32'(update_done), 32'd1);
        chk("mid pending_last", 32'(update_pending), 32'd0);
        mon_tvalid = 1'b0; mon_tlast = 1'b0;
        chk("mid pkt_count", pkt_count, 32'd1);
        chk("mid cut_pkt_count", cut_pkt_count, 32'd0);
        tick();

        // First word stalled in OUT_PKT blocks the commit
        mon_tvalid = 1'b1; mon_tready = 1'b0; mon_tlast = 1'b0; mon_tuser_len = 16'd60;
        do_update(1'b1, 32'd65);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("stall pending_c%0d", c), 32'(update_pending), 32'd1);
            chk($sformatf("stall bytes_c%0d", c), cut_bytes, 32'd100);
        end
        mon_tready = 1'b1;
        tick();
        chk("stall bytes_accept", cut_bytes, 32'd100);
        chk("stall pending_accept", 32'(update_pending), 32'd1);
        mon_tlast = 1'b1;
        tick();
        chk("stall bytes_end", cut_bytes, 32'd65);
        chk("stall words_end", cut_words, 32'd1);
        chk("stall offset_end", cut_offset, 32'h8000_0000);
        chk("stall pkt_count", pkt_count, 32'd2);
        chk("stall cut_pkt_count", cut_pkt_count, 32'd0);
        mon_tvalid = 1'b0; mon_tlast = 1'b0;
        tick();

        // Statistics: clear, reconfigure to 100 bytes, then three single-beat packets
        cfg_stats_clear = 1'b1;
        tick();
        cfg_stats_clear = 1'b0;
        chk("clear pkt_count", pkt_count, 32'd0);
        chk("clear cut_pkt_count", cut_pkt_count, 32'd0);
        do_update(1'b1, 32'd100);
        repeat (3) tick();
        chk("stats cut_bytes", cut_bytes, 32'd100);
        mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tlast = 1'b1;
        mon_tuser_len = 16'd60;   tick();
        mon_tuser_len = 16'd200;  tick();
        mon_tuser_len = 16'd1500; tick();
        mon_tvalid = 1'b0; mon_tlast = 1'b0;
        chk("stats pkt_count", pkt_count, 32'd3);
        chk("stats cut_pkt_count", cut_pkt_count, 32'd2);
        mon_tvalid = 1'b1; mon_tlast = 1'b1; mon_tuser_len = 16'd1500; cfg_stats_clear = 1'b1;
        tick();
        mon_tvalid = 1'b0; mon_tlast = 1'b0; cfg_stats_clear = 1'b0;
        chk("clr_beat pkt_count", pkt_count, 32'd0);
        chk("clr_beat cut_pkt_count", cut_pkt_count, 32'd0);

        // Back-to-back updates: last write wins, single commit
        cfg_cut_en = 1'b1; cfg_cut_len = 32'd100; cfg_update = 1'b1;
        tick();
        cfg_cut_len = 32'd300;
        tick();
        cfg_update = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (update_done) done_cnt++;
        end
        chk("b2b done pulses", 32'(done_cnt), 32'd1);
        chk("b2b cut_bytes", cut_bytes, 32'd300);
        chk("b2b cut_words", cut_words, 32'd8);
        chk("b2b cut_offset", cut_offset, 32'hfff0_0000);

        // Async reset while PENDING discards the update
        do_update(1'b1, 32'd64);
        tick();
        chk("rst pending_before", 32'(update_pending), 32'd1);
        #2 axi_resetn = 1'b0;
        #1;
        chk_reset_outputs("rst_async");
        tick();
        axi_resetn = 1'b1;
        repeat (4) tick();
        chk_reset_outputs("rst_released");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
